// File: rtl/bidir_transceiver.sv
// Registered WIDTH-bit bidirectional bridge between tristate ports A and B.
// A direction change always passes through an all-released turnaround window of TURN_CYCLES clocks.
module bidir_transceiver #(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir_req,
    inout  wire  [WIDTH-1:0] a_io,
    inout  wire  [WIDTH-1:0] b_io,
    output logic             a_oe,
    output logic             b_oe,
    output logic             dir_o,
    output logic             busy
);

    localparam int CW = $clog2(TURN_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRV_AB = 2'd1,
        DRV_BA = 2'd2,
        TURN   = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              dir_nxt;
    logic [WIDTH-1:0]  ab_q, ba_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dir_nxt   = dir_o;
        if (!en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = dir_req ? DRV_AB : DRV_BA;
                    dir_nxt   = dir_req;
                end
                DRV_AB: begin
                    if (!dir_req) begin
                        state_nxt = TURN;
                        cnt_nxt   = CW'(TURN_CYCLES - 1);
                    end
                end
                DRV_BA: begin
                    if (dir_req) begin
                        state_nxt = TURN;
                        cnt_nxt   = CW'(TURN_CYCLES - 1);
                    end
                end
                TURN: begin
                    // Direction is re-sampled only on the final edge of the window.
                    if (cnt == '0) begin
                        state_nxt = dir_req ? DRV_AB : DRV_BA;
                        dir_nxt   = dir_req;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            dir_o <= 1'b0;
            a_oe  <= 1'b0;
            b_oe  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dir_o <= dir_nxt;
            a_oe  <= (state_nxt == DRV_BA);
            b_oe  <= (state_nxt == DRV_AB);
            busy  <= (state_nxt == TURN);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ab_q <= '0;
            ba_q <= '0;
        end else begin
            ab_q <= a_io;
            ba_q <= b_io;
        end
    end

    assign b_io = b_oe ? ab_q : 'z;
    assign a_io = a_oe ? ba_q : 'z;

endmodule

// File: doc/bidir_transceiver.md
# bidir_transceiver

Parametrised, registered bidirectional bus transceiver between two tristate ports A and B. It replaces single-bit, purely combinational direction switching with a WIDTH-bit clocked datapath. A direction state machine guarantees a programmable all-released turnaround window on every direction change, so neither side is ever driven by this block while the other side is still being driven by it. Used wherever two shared buses are bridged under a direction request from a controller.

## Interface
- WIDTH, 8, data width of both ports (>= 1)
- TURN_CYCLES, 2, clock cycles both ports stay released on a direction change (>= 1)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  1 = transceiver active; 0 = both ports released
- dir_req  input  1  requested direction: 1 = A drives B, 0 = B drives A
- a_io  inout  WIDTH  port A
- b_io  inout  WIDTH  port B
- a_oe  output  1  1 = block is driving a_io
- b_oe  output  1  1 = block is driving b_io
- dir_o  output  1  direction currently driven (valid when a_oe or b_oe is 1)
- busy  output  1  1 while in turnaround

## Operation
- States: IDLE (both released), DRV_AB (b_io driven), DRV_BA (a_io driven), TURN (both released, counting).
- Reset: state IDLE; a_oe=b_oe=0, dir_o=0, busy=0, turn counter 0, data registers 0; a_io and b_io both high-Z.
- IDLE, en=1: next state DRV_AB if dir_req=1, else DRV_BA. There is no turnaround, because this block drives nothing in IDLE.
- DRV_x, en=1, dir_req matches current direction: stay.
- DRV_x, en=1, dir_req differs: go to TURN, load counter with TURN_CYCLES-1, busy=1, both oe=0.
- TURN: decrement the counter each cycle. When the counter is 0, leave TURN for DRV_AB/DRV_BA per dir_req sampled on that edge. The new direction may equal the old one; this is legal, and the window is still completed.
- en=0 in any state: next state IDLE, both oe=0, busy=0, counter cleared. Releasing the bus is always safe, so this is immediate.
- Datapath: on every edge, ab_q <= a_io and ba_q <= b_io. b_io = b_oe ? ab_q : 'z; a_io = a_oe ? ba_q : 'z.
- a_oe and b_oe are registered, decoded from state, and never both 1.
- dir_o updates on entry to a DRV state and holds through TURN and IDLE.
- Counter width is $clog2(TURN_CYCLES+1). There is no wrap-around, because the counter reloads only on TURN entry.

## Timing
- Enable latency: en and dir_req sampled high at edge k; the selected oe goes to 1 after edge k.
- Data latency: 1 cycle. The driven value in cycle m+1 equals the source port sampled at edge m.
- Direction change: new dir_req sampled at edge k. Old oe drops after edge k. New oe rises after edge k+TURN_CYCLES.
- Release window: exactly TURN_CYCLES full clock periods, with busy=1 for the same cycles.
- First value driven after turnaround is the source port sampled at the final TURN edge, which is the externally driven value.
- Async reset mid-drive or mid-TURN: both oe drop immediately, with no clock needed. On the first edge after rst deasserts, state leaves IDLE if en=1.
- dir_req toggling during TURN: ignored except at the final TURN edge. It neither extends nor shortens the window.
- en and dir_req changing on the same edge: en=0 has priority.

## Test plan
- Reset, then en=1, dir_req=1, drive a_io=8'hA5 -> b_oe=1 one cycle later; b_io=8'hA5 with 1-cycle lag; a_io never driven by the block.
- In DRV_AB with TURN_CYCLES=2, set dir_req=0 at edge k, external drives b_io=8'h3C -> a_oe=b_oe=0 and busy=1 for 2 cycles; a_oe=1 after edge k+2; a_io=8'h3C; a_oe&b_oe is never 1.
- During TURN, toggle dir_req 0->1->0 before the final edge -> window stays 2 cycles; the final direction follows dir_req at the last edge.
- Drop en mid-TURN and mid-DRV_BA -> both oe=0 after the next edge, busy=0; re-enable -> direct entry to the DRV state with no turnaround.
- Assert rst asynchronously between edges while driving -> a_io and b_io high-Z immediately; all outputs at reset values.
- Sweep WIDTH=1/16 and TURN_CYCLES=1/5 with random en/dir_req -> oe mutual exclusion holds; every release window equals TURN_CYCLES; data matches the source sampled one cycle earlier.
